// File: rtl/arima_ctrl.sv
// arima_ctrl: sequencer for the ARIMA datapath stage controls and training/forecast flow control.
// Define ARIMA_CTRL_OVF_ABORT_EN to abort into ERR on dp_overflow.
module arima_ctrl #(
  parameter int N     = 32,
  parameter int d_max = 10,
  parameter int p_max = 10,
  parameter int q_max = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] n_train,
  input  logic [N-1:0] horizon,
  input  logic [N-1:0] d_order,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         m_valid,
  input  logic         m_ready,
  input  logic         dp_overflow,
  output logic [1:0]   c_diff,
  output logic [1:0]   c_ar,
  output logic [1:0]   c_ma,
  output logic [1:0]   c_inte,
  output logic         sel_inte_in,
  output logic         busy,
  output logic         done,
  output logic         err
);
  if (p_max < 1 || q_max < 1 || d_max < 0) begin : g_bad_cfg
    $error("arima_ctrl: AR/MA orders must be positive");
  end
  typedef enum logic [2:0] {IDLE, CLEAR, TRAIN, FSTEP, FOUT, DONE, ERR} state_e;
  localparam logic [1:0] HOLD = 2'b00, CLR = 2'b01, SHIFT = 2'b10;
  localparam logic [N-1:0] D_SAT = N'(d_max);
  state_e state_q, state_d;
  logic [N-1:0] train_q, train_d, fc_q, fc_d, n_q, n_d, h_q, h_d, d_q, d_d;
  logic abort;
`ifdef ARIMA_CTRL_OVF_ABORT_EN
  assign abort = dp_overflow && (state_q == TRAIN || state_q == FSTEP || state_q == FOUT);
`else
  assign abort = 1'b0 && dp_overflow;
`endif
  assign s_ready = state_q == TRAIN;
  assign m_valid = state_q == FOUT;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign err     = state_q == ERR;
  always_comb begin
    state_d     = state_q;
    train_d     = train_q;
    fc_d        = fc_q;
    n_d         = n_q;
    h_d         = h_q;
    d_d         = d_q;
    c_diff      = HOLD;
    c_ar        = HOLD;
    c_ma        = HOLD;
    c_inte      = HOLD;
    sel_inte_in = 1'b1;
    case (state_q)
      IDLE, ERR: if (start) begin
        state_d = CLEAR;
        n_d     = n_train;
        h_d     = horizon;
        d_d     = (d_order > D_SAT) ? D_SAT : d_order;
      end
      CLEAR: begin
        {c_diff, c_ar, c_ma, c_inte} = {4{CLR}};
        train_d = '0;
        fc_d    = '0;
        state_d = (n_q != '0) ? TRAIN : (h_q != '0) ? FSTEP : DONE;
      end
      // differenced samples are meaningless until d_order of them have been seen
      TRAIN: if (s_valid) begin
        c_diff  = SHIFT;
        c_inte  = SHIFT;
        c_ar    = (train_q >= d_q) ? SHIFT : HOLD;
        c_ma    = (train_q >= d_q) ? SHIFT : HOLD;
        train_d = train_q + 1'b1;
        if (train_d == n_q) state_d = (h_q != '0) ? FSTEP : DONE;
      end
      FSTEP: begin
        sel_inte_in = 1'b0;
        c_ar        = SHIFT;
        c_ma        = SHIFT;
        c_inte      = SHIFT;
        state_d     = FOUT;
      end
      FOUT: begin
        sel_inte_in = 1'b0;
        if (m_ready) begin
          fc_d    = fc_q + 1'b1;
          state_d = (fc_d < h_q) ? FSTEP : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = ERR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      train_q <= '0;
      fc_q    <= '0;
      n_q     <= '0;
      h_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      fc_q    <= fc_d;
      n_q     <= n_d;
      h_q     <= h_d;
      d_q     <= d_d;
    end
  end
endmodule

// File: tb/tb_arima_ctrl.sv
// tb_arima_ctrl: randomized scoreboard bench; expected event sequence per run is derived from the run parameters.
module tb_arima_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b0, dp_overflow = 1'b0;
  logic [31:0] n_train = '0, horizon = '0, d_order = '0;
  logic        s_ready, m_valid, sel_inte_in, busy, done, err;
  logic [1:0]  c_diff, c_ar, c_ma, c_inte;
  int checks = 0, errors = 0;
  bit mon_en = 1'b0, done_seen = 1'b0, prev_mv = 1'b0, prev_hsm = 1'b0, prev_done = 1'b0;
  localparam logic [7:0] EV_CLEAR = 1, EV_TRAIN = 2, EV_STEP = 3, EV_OUT = 4, EV_DONE = 5;
`ifdef ARIMA_CTRL_OVF_ABORT_EN
  localparam bit OVF_ABORT = 1'b1;
`else
  localparam bit OVF_ABORT = 1'b0;
`endif
  typedef struct packed {logic [7:0] kind; logic [7:0] ctl;} ev_t;
  ev_t sb[$];

  arima_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_train(n_train), .horizon(horizon), .d_order(d_order),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .dp_overflow(dp_overflow),
    .c_diff(c_diff), .c_ar(c_ar), .c_ma(c_ma), .c_inte(c_inte), .sel_inte_in(sel_inte_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic obs(input logic [7:0] kind, input logic [7:0] ctl);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_extra got kind %0d ctl %0h want no event", kind, ctl);
    end else begin
      e = sb.pop_front();
      chk("sb_event", {kind, ctl}, e);
    end
  endtask

  // monitor: classify each cycle into a transaction-level event and check invariants
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("no_ctl_11", {c_diff == 2'b11, c_ar == 2'b11, c_ma == 2'b11, c_inte == 2'b11}, 0);
      if (s_ready && !s_valid) chk("train_idle_hold", {c_diff, c_ar, c_ma, c_inte}, 0);
      if (m_valid) chk("fout_hold", {c_diff, c_ar, c_ma, c_inte, sel_inte_in}, 0);
      if (prev_mv && !prev_hsm) chk("mv_no_drop", m_valid | err, 1);
      if (prev_done) chk("done_one_cycle", done, 0);
      if (c_diff == 2'b01) begin
        chk("clear_err_busy", {err, busy}, 2'b01);
        obs(EV_CLEAR, {c_diff, c_ar, c_ma, c_inte});
      end else if (s_valid && s_ready) begin
        chk("train_sel", sel_inte_in, 1);
        obs(EV_TRAIN, {c_diff, c_ar, c_ma, c_inte});
      end else if (!sel_inte_in && c_inte == 2'b10) obs(EV_STEP, {c_diff, c_ar, c_ma, c_inte});
      if (m_valid && m_ready) obs(EV_OUT, {c_diff, c_ar, c_ma, c_inte});
      if (done) begin
        chk("done_quiet", {s_ready, m_valid}, 0);
        obs(EV_DONE, {c_diff, c_ar, c_ma, c_inte});
        done_seen = 1'b1;
      end
    end
    prev_mv   = m_valid;
    prev_hsm  = m_valid && m_ready;
    prev_done = done;
  end

  task automatic run(input int n, input int h, input int d, input int sv_pct, input int mr_pct,
                     input int stall_in, input bit ovf);
    int  cyc = 0, stall = stall_in, dsat = (d > 10) ? 10 : d;
    bit  aborted = 1'b0, ovf_done = 1'b0, ab = ovf && OVF_ABORT && h > 0;
    sb.push_back({EV_CLEAR, 8'h55});
    for (int k = 0; k < n; k++) sb.push_back({EV_TRAIN, (k >= dsat) ? 8'hAA : 8'h82});
    for (int j = 0; j < h; j++) begin
      sb.push_back({EV_STEP, 8'h2A});
      if (ab) break;
      sb.push_back({EV_OUT, 8'h00});
    end
    if (!ab) sb.push_back({EV_DONE, 8'h00});
    done_seen = 1'b0;
    n_train = n; horizon = h; d_order = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done_seen && !aborted && cyc < 3000) begin
      s_valid = $urandom_range(99) < sv_pct;
      m_ready = $urandom_range(99) < mr_pct;
      start   = $urandom_range(9) == 0;
      n_train = $urandom; horizon = $urandom; d_order = $urandom;
      if (stall > 0 && m_valid) begin
        m_ready = 1'b0;
        stall--;
      end
      if (ovf && m_valid && !ovf_done) begin
        ovf_done = 1'b1;
        m_ready = 1'b0; start = 1'b0; dp_overflow = 1'b1;
        @(posedge clk); #1;
        dp_overflow = 1'b0;
        if (OVF_ABORT) begin
          chk("ovf_abort", {err, m_valid, s_ready, busy}, 4'b1001);
          aborted = 1'b1;
        end else chk("ovf_ignored", {err, m_valid}, 2'b01);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_end", done_seen | aborted, 1);
    s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1;
    chk("reset_outs", {c_diff, c_ar, c_ma, c_inte, sel_inte_in, s_ready, m_valid, busy, done, err}, 14'h20);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // reset mid-TRAIN with latency checks, monitor off
    n_train = 8; horizon = 2; d_order = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_clear", {c_diff, busy, s_ready}, 4'b0110);
    @(posedge clk); #1;
    chk("lat_ready", s_ready, 1);
    s_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    s_valid = 1'b0;
    chk("mid_train", {s_ready, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {c_diff, c_ar, c_ma, c_inte, sel_inte_in, s_ready, m_valid, busy, done, err}, 14'h20);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", busy, 0);
    mon_en = 1'b1;
    run(5, 3, 2, 100, 70, 0, 0);
    run(4, 3, 0, 100, 100, 4, 0);
    run(0, 0, 3, 60, 60, 0, 0);
    run(6, 2, 1, 50, 50, 0, 0);
    run(13, 2, 15, 80, 80, 0, 0);
    run(0, 4, 0, 50, 40, 0, 0);
    run(3, 3, 1, 100, 100, 0, 1);
    run(2, 1, 0, 70, 70, 0, 0);
    for (int r = 0; r < 10; r++)
      run($urandom_range(12), $urandom_range(6), $urandom_range(14), $urandom_range(30, 100),
          $urandom_range(30, 100), $urandom_range(3), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
